// File: rtl/sede_frame_host.sv
// -----------------------------------------------------------------------------
// sede_frame_host
// Frame host for the Sobel edge engine.
//
// Operation:
//   - A start pulse restarts the engine.
//   - One IMG_W x IMG_H grayscale frame is streamed from the image ROM to the
//     engine, one pixel per cycle with no gaps.
//   - The engine's valid/edge result stream is captured into the result RAM.
//   - done and err report the outcome of the frame.
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   start                 1-cycle frame request, honoured only while idle
//   img_addr / img_q      image ROM address out, read data in (1-cycle latency)
//   eng_rst               registered active-high engine restart
//   pix_data              pixel to engine (img_q while feeding, else 0)
//   eng_valid/eng_edge    engine result stream
//   eng_busy              engine draining flag (observed only)
//   res_we/res_addr/res_d registered result RAM write port
//   busy / done / err     frame in progress, end-of-frame pulse, sticky error
//
// Optional feature (macro SEDE_CKSUM_EN):
//   - Adds output cksum[15:0], the modulo-2^16 sum of every res_d written in
//     the current frame.
//   - cksum is cleared on start accept.
// -----------------------------------------------------------------------------
module sede_frame_host #(
  parameter int IMG_W   = 32,
  parameter int IMG_H   = 32,
  parameter int AW      = 10,
  parameter int TIMEOUT = 2200
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [AW-1:0] img_addr,
  input  logic [7:0]    img_q,
  output logic          eng_rst,
  output logic [7:0]    pix_data,
  input  logic          eng_valid,
  input  logic [7:0]    eng_edge,
  input  logic          eng_busy,
  output logic          res_we,
  output logic [AW-1:0] res_addr,
  output logic [7:0]    res_d,
  output logic          busy,
  output logic          done,
`ifdef SEDE_CKSUM_EN
  output logic          err,
  output logic [15:0]   cksum
`else
  output logic          err
`endif
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int WW   = $clog2(TIMEOUT + 1);

  localparam logic [AW:0]   NPIX_C   = (AW+1)'(NPIX);
  localparam logic [AW-1:0] LAST_C   = AW'(NPIX - 1);
  localparam logic [AW-1:0] NEAR_C   = AW'(NPIX - 2);
  localparam logic [WW-1:0] WD_LAST_C = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ERST  = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t        state_r;
  logic [AW-1:0] pcnt_r;
  logic [AW:0]   rcnt_r;
  logic [WW-1:0] wcnt_r;
  logic          valid_q_r;
  logic [AW-1:0] img_addr_r;
  logic          eng_rst_r;
  logic          res_we_r;
  logic [AW-1:0] res_addr_r;
  logic [7:0]    res_d_r;
  logic          busy_r;
  logic          done_r;
  logic          err_r;

  logic          capture_s;
  logic          room_s;
  logic          gap_s;
  logic          nat_fin_s;
  logic          wdog_s;
  logic [7:0]    pix_s;
  logic          unused_s;

  // eng_busy is informational only and intentionally left unobserved.
  assign unused_s = eng_busy;

  // Decode the capture window, result room, valid gap, natural end and watchdog expiry.
  always_comb begin
    capture_s = (state_r == S_FEED) || (state_r == S_DRAIN);
    room_s    = (rcnt_r < NPIX_C);
    gap_s     = valid_q_r && !eng_valid && (rcnt_r != {(AW+1){1'b0}}) && room_s;
    nat_fin_s = (state_r == S_DRAIN) && (rcnt_r == NPIX_C);
    // The watchdog fires so that FIN is occupied exactly when wcnt reaches TIMEOUT.
    wdog_s    = busy_r && (state_r != S_FIN) && (wcnt_r == WD_LAST_C) && !nat_fin_s;
  end

  // Pixel pass-through to the engine while feeding, zero otherwise.
  always_comb begin
    if (state_r == S_FEED) begin
      pix_s = img_q;
    end else begin
      pix_s = 8'h00;
    end
  end

  // Frame sequencing, ROM addressing, result capture, error tracking and watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      pcnt_r     <= {AW{1'b0}};
      rcnt_r     <= {(AW+1){1'b0}};
      wcnt_r     <= {WW{1'b0}};
      valid_q_r  <= 1'b0;
      img_addr_r <= {AW{1'b0}};
      eng_rst_r  <= 1'b1;
      res_we_r   <= 1'b0;
      res_addr_r <= {AW{1'b0}};
      res_d_r    <= 8'h00;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      res_we_r  <= 1'b0;
      done_r    <= 1'b0;
      valid_q_r <= eng_valid;
      if (busy_r) begin
        wcnt_r <= wcnt_r + {{(WW-1){1'b0}}, 1'b1};
      end

      if (capture_s) begin
        if (eng_valid && room_s) begin
          res_we_r   <= 1'b1;
          res_addr_r <= rcnt_r[AW-1:0];
          res_d_r    <= eng_edge;
          rcnt_r     <= rcnt_r + {{AW{1'b0}}, 1'b1};
        end else if (eng_valid) begin
          // Result beyond the frame: flag it, write nothing.
          err_r <= 1'b1;
        end else if (gap_s) begin
          err_r <= 1'b1;
        end
      end

      case (state_r)
        S_IDLE: begin
          eng_rst_r  <= 1'b1;
          img_addr_r <= {AW{1'b0}};
          if (start) begin
            err_r   <= 1'b0;
            busy_r  <= 1'b1;
            pcnt_r  <= {AW{1'b0}};
            rcnt_r  <= {(AW+1){1'b0}};
            // Counts the start cycle as 0, so wcnt equals cycles since start.
            wcnt_r  <= {{(WW-1){1'b0}}, 1'b1};
            state_r <= S_ERST;
          end
        end
        S_ERST: begin
          eng_rst_r  <= 1'b0;
          img_addr_r <= {{(AW-1){1'b0}}, 1'b1};
          pcnt_r     <= {AW{1'b0}};
          state_r    <= S_FEED;
        end
        S_FEED: begin
          pcnt_r <= pcnt_r + {{(AW-1){1'b0}}, 1'b1};
          // The ROM address runs one ahead of pcnt and parks on the last pixel.
          if (pcnt_r >= NEAR_C) begin
            img_addr_r <= LAST_C;
          end else begin
            img_addr_r <= pcnt_r + {{(AW-2){1'b0}}, 2'd2};
          end
          if (pcnt_r == LAST_C) begin
            state_r <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (nat_fin_s) begin
            done_r  <= 1'b1;
            state_r <= S_FIN;
          end
        end
        S_FIN: begin
          busy_r    <= 1'b0;
          eng_rst_r <= 1'b1;
          state_r   <= S_IDLE;
        end
        default: begin
          busy_r    <= 1'b0;
          eng_rst_r <= 1'b1;
          state_r   <= S_IDLE;
        end
      endcase

      if (wdog_s) begin
        err_r   <= 1'b1;
        done_r  <= 1'b1;
        state_r <= S_FIN;
      end
    end
  end

`ifdef SEDE_CKSUM_EN
  logic [15:0] cksum_r;

  // Running sum of the result data actually written in this frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cksum_r <= 16'h0000;
    end else if ((state_r == S_IDLE) && start) begin
      cksum_r <= 16'h0000;
    end else if (res_we_r) begin
      cksum_r <= cksum_r + {8'h00, res_d_r};
    end else begin
      cksum_r <= cksum_r;
    end
  end

  assign cksum = cksum_r;
`endif

  assign img_addr = img_addr_r;
  assign eng_rst  = eng_rst_r;
  assign pix_data = pix_s;
  assign res_we   = res_we_r;
  assign res_addr = res_addr_r;
  assign res_d    = res_d_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;

endmodule

// File: tb/tb_sede_frame_host.sv
// Testbench for sede_frame_host: image ROM and engine models, a cycle-level
// frame model derived from the frame timeline, and directed frame scenarios.
module tb_sede_frame_host;

  localparam int NPIX    = 1024;
  localparam int AW      = 10;
  localparam int TIMEOUT = 2200;

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic [AW-1:0] img_addr, res_addr;
  logic [7:0]    img_q, pix_data, eng_edge, res_d;
  logic          eng_rst, eng_valid, eng_busy, res_we, busy, done, err;
`ifdef SEDE_CKSUM_EN
  logic [15:0]   cksum;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] rom    [NPIX];
  logic [7:0] ram    [NPIX];
  logic [7:0] in_pix [NPIX];

  // engine model configuration and state
  int         eng_lat;
  int         drop_at;
  logic [7:0] eng_xor;
  int         t, in_cnt, out_idx;
  bit         dropped;

  // frame model state (n = cycles since the start cycle)
  bit         in_frame, have_vc, err_exp, exp_we, prev_v;
  int         n, vc, vcount, wr_count, done_cycle;
  int         exp_addr;
  logic [7:0] exp_d;
  logic [15:0] sum_exp;

  sede_frame_host dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .img_addr(img_addr), .img_q(img_q),
    .eng_rst(eng_rst), .pix_data(pix_data),
    .eng_valid(eng_valid), .eng_edge(eng_edge), .eng_busy(eng_busy),
    .res_we(res_we), .res_addr(res_addr), .res_d(res_d),
    .busy(busy), .done(done),
`ifdef SEDE_CKSUM_EN
    .err(err), .cksum(cksum)
`else
    .err(err)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous image ROM: data for an address appears one cycle later.
  initial begin
    img_q = 8'h00;
    forever begin
      @(posedge clk);
      img_q <= rom[img_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Earliest natural FIN cycle: two cycles after the last result, never before NPIX+3.
  function automatic int natural_fin();
    int f;
    if (!have_vc) return TIMEOUT + 1;
    f = vc + 2;
    if (f < NPIX + 3) f = NPIX + 3;
    return f;
  endfunction

  function automatic int model_fin();
    int f;
    f = natural_fin();
    return (f < TIMEOUT) ? f : TIMEOUT;
  endfunction

  // Per-cycle compare, engine model and frame model, all at the falling edge.
  initial begin : monitor
    int fin;
    bit win, feed_now;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_err",      32'(err),      32'd0);
        chk("rst_res_we",   32'(res_we),   32'd0);
        chk("rst_eng_rst",  32'(eng_rst),  32'd1);
        chk("rst_pix_data", 32'(pix_data), 32'd0);
        chk("rst_img_addr", 32'(img_addr), 32'd0);
        chk("rst_res_addr", 32'(res_addr), 32'd0);
        chk("rst_res_d",    32'(res_d),    32'd0);
        in_frame = 1'b0; err_exp = 1'b0; exp_we = 1'b0; prev_v = 1'b0; have_vc = 1'b0;
      end else begin
        fin = model_fin();
        feed_now = in_frame && (n >= 2) && (n <= NPIX + 1) && (n < fin);
        chk("busy",    32'(busy),    32'(in_frame));
        chk("done",    32'(done),    32'(in_frame && (n == fin)));
        chk("eng_rst", 32'(eng_rst), 32'(!(in_frame && (n >= 2) && (n <= fin))));
        chk("pix_data", 32'(pix_data), feed_now ? 32'(rom[n-2]) : 32'd0);
        chk("err",     32'(err),     32'(err_exp));
        chk("res_we",  32'(res_we),  32'(exp_we));
        if (exp_we) begin
          chk("res_addr", 32'(res_addr), 32'(exp_addr));
          chk("res_d",    32'(res_d),    32'(exp_d));
        end
        if (res_we) begin
          ram[res_addr] = res_d;
          wr_count++;
        end
        if (done) done_cycle = n;
      end

      // engine: restarts while eng_rst is high, otherwise consumes one pixel per
      // cycle and returns f(pixel) eng_lat cycles later, optionally skipping a slot
      if (eng_rst) begin
        t = 0; in_cnt = 0; out_idx = 0; dropped = 1'b0;
        eng_valid = 1'b0; eng_edge = 8'h00;
      end else begin
        if (in_cnt < NPIX) begin
          in_pix[in_cnt] = pix_data;
          in_cnt++;
        end
        if ((t >= eng_lat) && (out_idx < NPIX)) begin
          if ((out_idx == drop_at) && !dropped) begin
            dropped = 1'b1;
            eng_valid = 1'b0;
          end else begin
            eng_valid = 1'b1;
            eng_edge = in_pix[out_idx] ^ eng_xor;
            out_idx++;
          end
        end else begin
          eng_valid = 1'b0;
        end
        t++;
      end
      eng_busy = eng_valid;

      if (rst_n) begin
        win = in_frame && (n >= 2) && (n < fin);
        exp_we = 1'b0;
        if (win) begin
          if (eng_valid) begin
            if (vcount < NPIX) begin
              exp_we = 1'b1; exp_addr = vcount; exp_d = eng_edge;
              sum_exp = sum_exp + {8'h00, eng_edge};
              vcount++;
              if (vcount == NPIX) begin have_vc = 1'b1; vc = n; end
            end else begin
              err_exp = 1'b1;
            end
          end else if (prev_v && (vcount > 0) && (vcount < NPIX)) begin
            err_exp = 1'b1;
          end
        end
        if (in_frame && (n == TIMEOUT - 1) && (natural_fin() > TIMEOUT)) err_exp = 1'b1;
        prev_v = eng_valid;
        if (in_frame && (n == fin)) begin
          in_frame = 1'b0;
        end else if (in_frame) begin
          n++;
        end else if (start) begin
          in_frame = 1'b1; n = 1; have_vc = 1'b0; vcount = 0; err_exp = 1'b0;
          wr_count = 0; sum_exp = 16'h0000; done_cycle = -1;
        end
      end
    end
  end

  task automatic wait_cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (in_frame && (i < 3000)) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk("frame_end_bound", 32'(in_frame), 32'd0);
    wait_cyc(2);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    eng_valid = 1'b0; eng_edge = 8'h00; eng_busy = 1'b0;
    eng_lat = 33; drop_at = -1; eng_xor = 8'hA5;
    in_frame = 1'b0; have_vc = 1'b0; err_exp = 1'b0; exp_we = 1'b0; prev_v = 1'b0;
    n = 0; vc = 0; vcount = 0; wr_count = 0; done_cycle = -1; exp_addr = 0;
    exp_d = 8'h00; sum_exp = 16'h0000;
    for (int k = 0; k < NPIX; k++) begin
      rom[k] = k[7:0];
      ram[k] = 8'h00;
    end

    // 1: reset, then a long idle stretch
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_cyc(50);
    chk("idle_writes",  32'(wr_count), 32'd0);
    chk("idle_eng_rst", 32'(eng_rst),  32'd1);
    chk("idle_busy",    32'(busy),     32'd0);

    // 2: ramp frame, engine latency 33, result = pixel ^ 0xA5
    pulse_start();
    wait_idle();
    chk("ramp_writes", 32'(wr_count),   32'd1024);
    chk("ramp_done",   32'(done_cycle), 32'd1060);
    chk("ramp_err",    32'(err),        32'd0);
    chk("ramp_ram0",   32'(ram[0]),     32'h0000_00A5);
    chk("ramp_ram300", 32'(ram[300]),   32'h0000_0089);
    chk("ramp_ram1023", 32'(ram[1023]), 32'h0000_005A);

    // 3: engine skips one slot after 500 results
    drop_at = 500;
    pulse_start();
    wait_idle();
    chk("gap_err",    32'(err),        32'd1);
    chk("gap_done",   32'(done_cycle), 32'd1061);
    chk("gap_writes", 32'(wr_count),   32'd1024);
    drop_at = -1;

    // 4: engine never answers, the watchdog ends the frame
    eng_lat = 1000000;
    pulse_start();
    wait_idle();
    chk("wdog_done",   32'(done_cycle), 32'd2200);
    chk("wdog_err",    32'(err),        32'd1);
    chk("wdog_writes", 32'(wr_count),   32'd0);
    eng_lat = 33;

    // 5: extra start pulses in FEED (cycle 100) and in FIN (cycle 1060)
    pulse_start();
    wait_cyc(99);
    pulse_start();
    wait_cyc(959);
    pulse_start();
    wait_idle();
    chk("restart_done",   32'(done_cycle), 32'd1060);
    chk("restart_busy",   32'(busy),       32'd0);
    chk("restart_err",    32'(err),        32'd0);
    chk("restart_writes", 32'(wr_count),   32'd1024);

    // 6: reset at pcnt = 300, then an all-0xFF frame through a pass-through engine
    pulse_start();
    wait_cyc(301);
    rst_n = 1'b0;
    #1;
    chk("abort_busy",    32'(busy),    32'd0);
    chk("abort_eng_rst", 32'(eng_rst), 32'd1);
    chk("abort_res_we",  32'(res_we),  32'd0);
    wait_cyc(2);
    rst_n = 1'b1;
    for (int k = 0; k < NPIX; k++) rom[k] = 8'hFF;
    eng_lat = 1; eng_xor = 8'h00;
    wait_cyc(3);
    pulse_start();
    wait_idle();
    chk("clean_writes", 32'(wr_count),   32'd1024);
    chk("clean_err",    32'(err),        32'd0);
    chk("clean_done",   32'(done_cycle), 32'd1028);
    chk("clean_ram512", 32'(ram[512]),   32'h0000_00FF);
`ifdef SEDE_CKSUM_EN
    chk("cksum_model", 32'(cksum), 32'(sum_exp));
    // 1024 * 0xFF = 0x3FC00
    chk("cksum_ff",    32'(cksum), 32'h0000_FC00);
`endif

    wait_cyc(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
